// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package cla_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_serial_adder_if.sv
// Operand/result valid-ready bundle for cla_serial_adder; ovf exists only with CLA_SERIAL_OVF_EN.
interface cla_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CLA_SERIAL_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/cla_4bit.sv
// Combinational 4-bit carry-lookahead adder stage; zero latency, no flow control.
module cla_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;

    assign w_g = A & B;
    assign w_p = A ^ B;

    // Every carry is a flat sum of products from Cin, so no ripple through the nibble.
    assign w_c[0] = Cin;
    assign w_c[1] = w_g[0] | (w_p[0] & Cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & Cin);
    assign Cout   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & Cin);

    assign Sum = w_p ^ w_c;
endmodule

// File: rtl/cla_serial_adder.sv
// WIDTH-bit adder run one nibble per clock through a single cla_4bit; result valid NIB cycles after acceptance.
// Result held stable under out_ready backpressure; signed overflow output enabled by CLA_SERIAL_OVF_EN.
module cla_serial_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    cla_serial_adder_if.slave   bus
);
    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = $clog2(NIB) + 1;

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
        $fatal(1, "cla_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;

    logic [NIBBLE_W-1:0] w_nib_sum;
    logic                w_nib_cout;
    logic [WIDTH-1:0]    w_sum_shift;
    logic                w_accept;
    logic                w_last;

    cla_4bit u_cla (
        .A    (r_a[NIBBLE_W-1:0]),
        .B    (r_b[NIBBLE_W-1:0]),
        .Cin  (r_carry),
        .Sum  (w_nib_sum),
        .Cout (w_nib_cout)
    );

    // Each new nibble enters at the top, so after NIB steps the LSB nibble sits at the bottom.
    if (NIB == 1) begin : g_one_nib
        assign w_sum_shift = w_nib_sum;
    end else begin : g_multi_nib
        assign w_sum_shift = {w_nib_sum, r_sum[WIDTH-1:NIBBLE_W]};
    end

    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_last   = (r_cnt == CNT_W'(NIB - 1));

    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a     <= bus.a;
                r_b     <= bus.b;
                r_carry <= bus.cin;
                r_cnt   <= '0;
                r_sum   <= '0;
            end else if (r_state == RUN) begin
                r_a     <= r_a >> NIBBLE_W;
                r_b     <= r_b >> NIBBLE_W;
                r_sum   <= w_sum_shift;
                r_carry <= w_nib_cout;
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.sum  = r_sum;
    assign bus.cout = r_carry;

`ifdef CLA_SERIAL_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.b[WIDTH-1];
            r_ovf   <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            // The final stage's top sum bit is the result MSB.
            r_ovf <= (r_a_msb == r_b_msb) && (w_nib_sum[NIBBLE_W-1] != r_a_msb);
        end
    end

    assign bus.ovf = r_ovf;
`endif
endmodule

// File: tb/tb_cla_serial_adder.sv
// Directed-vector bench for cla_serial_adder at WIDTH=16 and WIDTH=4 (ovf vectors with CLA_SERIAL_OVF_EN).
module tb_cla_serial_adder;
    logic clk;
    logic rst;

    cla_serial_adder_if #(.WIDTH(16)) b16 ();
    cla_serial_adder_if #(.WIDTH(4))  b4 ();

    cla_serial_adder #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(b16.slave));
    cla_serial_adder #(.WIDTH(4))  u_dut4  (.clk(clk), .rst(rst), .bus(b4.slave));

    int n_vec = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait16(output int lat);
        lat = 0;
        while (!b16.out_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (lat >= 50) check("timeout16", 32'(lat), 32'd0);
    endtask

    task automatic wait4(output int lat);
        lat = 0;
        while (!b4.out_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (lat >= 50) check("timeout4", 32'(lat), 32'd0);
    endtask

    initial begin
        int lat;
        int n;
        rst = 1'b1;
        b16.in_valid = 1'b0; b16.a = '0; b16.b = '0; b16.cin = 1'b0; b16.out_ready = 1'b1;
        b4.in_valid  = 1'b0; b4.a  = '0; b4.b  = '0; b4.cin  = 1'b0; b4.out_ready  = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_in_ready",  32'(b16.in_ready),  32'd1);
        check("rst_out_valid", 32'(b16.out_valid), 32'd0);
        check("rst_sum",       32'(b16.sum),       32'd0);
        check("rst_cout",      32'(b16.cout),      32'd0);
        check("rst_in_ready4", 32'(b4.in_ready),   32'd1);
`ifdef CLA_SERIAL_OVF_EN
        check("rst_ovf",       32'(b16.ovf),       32'd0);
`endif

        // FFFF + 0001: carry ripples through every nibble
        b16.a = 16'hFFFF; b16.b = 16'h0001; b16.cin = 1'b0; b16.in_valid = 1'b1;
        tick();
        b16.in_valid = 1'b0;
        check("t1_run_in_ready", 32'(b16.in_ready), 32'd0);
        wait16(lat);
        check("t1_latency", 32'(lat), 32'd4);
        check("t1_sum",  32'(b16.sum),  32'h0000);
        check("t1_cout", 32'(b16.cout), 32'd1);
        tick();
        check("t1_idle_in_ready",  32'(b16.in_ready),  32'd1);
        check("t1_idle_out_valid", 32'(b16.out_valid), 32'd0);

        // 1234 + 4321 + 1 with in_valid held and operands changed after acceptance
        b16.a = 16'h1234; b16.b = 16'h4321; b16.cin = 1'b1; b16.in_valid = 1'b1;
        tick();
        b16.a = 16'hFFFF; b16.b = 16'hFFFF; b16.cin = 1'b0;
        wait16(lat);
        check("t2_sum",      32'(b16.sum),      32'h5556);
        check("t2_cout",     32'(b16.cout),     32'd0);
        check("t2_in_ready", 32'(b16.in_ready), 32'd0);
        b16.in_valid = 1'b0;
        tick();
        check("t2_idle", 32'(b16.in_ready), 32'd1);
        repeat (3) tick();
        check("t2_single_op", 32'(b16.out_valid), 32'd0);

        // Backpressure: result must hold for three refused cycles
        b16.out_ready = 1'b0;
        b16.a = 16'h00FF; b16.b = 16'h0F0F; b16.cin = 1'b0; b16.in_valid = 1'b1;
        tick();
        b16.in_valid = 1'b0;
        wait16(lat);
        check("t3_sum", 32'(b16.sum), 32'h100E);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_hold_sum",       32'(b16.sum),       32'h100E);
            check("t3_hold_cout",      32'(b16.cout),      32'd0);
            check("t3_hold_out_valid", 32'(b16.out_valid), 32'd1);
            check("t3_hold_in_ready",  32'(b16.in_ready),  32'd0);
        end
        b16.out_ready = 1'b1;
        tick();
        check("t3_release_in_ready",  32'(b16.in_ready),  32'd1);
        check("t3_release_out_valid", 32'(b16.out_valid), 32'd0);

        // Reset on the second RUN cycle aborts the operation
        b16.a = 16'hAAAA; b16.b = 16'h5555; b16.cin = 1'b0; b16.in_valid = 1'b1;
        tick();
        b16.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_in_ready",  32'(b16.in_ready),  32'd1);
        check("t4_out_valid", 32'(b16.out_valid), 32'd0);
        check("t4_sum",       32'(b16.sum),       32'd0);
        check("t4_cout",      32'(b16.cout),      32'd0);
        b16.a = 16'h0001; b16.b = 16'h0001; b16.cin = 1'b0; b16.in_valid = 1'b1;
        tick();
        b16.in_valid = 1'b0;
        wait16(lat);
        check("t4_after_sum",  32'(b16.sum),  32'h0002);
        check("t4_after_cout", 32'(b16.cout), 32'd0);
        tick();

`ifdef CLA_SERIAL_OVF_EN
        b16.a = 16'h7FFF; b16.b = 16'h0001; b16.cin = 1'b0; b16.in_valid = 1'b1;
        tick();
        b16.in_valid = 1'b0;
        wait16(lat);
        check("t5a_sum",  32'(b16.sum),  32'h8000);
        check("t5a_ovf",  32'(b16.ovf),  32'd1);
        check("t5a_cout", 32'(b16.cout), 32'd0);
        tick();
        b16.a = 16'hFFFF; b16.b = 16'h0001; b16.cin = 1'b0; b16.in_valid = 1'b1;
        tick();
        b16.in_valid = 1'b0;
        wait16(lat);
        check("t5b_sum",  32'(b16.sum),  32'h0000);
        check("t5b_ovf",  32'(b16.ovf),  32'd0);
        check("t5b_cout", 32'(b16.cout), 32'd1);
        tick();
`endif

        // WIDTH=4: single-nibble latency and back-to-back issue period
        b4.a = 4'hF; b4.b = 4'hF; b4.cin = 1'b1; b4.in_valid = 1'b1;
        tick();
        b4.a = 4'h3; b4.b = 4'h4; b4.cin = 1'b0;
        wait4(lat);
        check("t6_latency", 32'(lat), 32'd1);
        check("t6_sum",  32'(b4.sum),  32'hF);
        check("t6_cout", 32'(b4.cout), 32'd1);
        n = lat;
        while (!b4.in_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        n++;
        check("t6_reaccept", 32'(b4.in_ready), 32'd0);
        check("t6_period",   32'(n),           32'd3);
        b4.in_valid = 1'b0;
        wait4(lat);
        check("t6b_latency", 32'(lat), 32'd1);
        check("t6b_sum",  32'(b4.sum),  32'h7);
        check("t6b_cout", 32'(b4.cout), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cla_serial_adder.md
# cla_serial_adder

Multi-cycle wide adder that streams a WIDTH-bit operand pair through one 4-bit carry-lookahead adder stage, one nibble per clock, LSB nibble first. It sits directly upstream of that stage, feeding its A/B/Cin inputs. It consumes the stage's Sum/Cout each cycle, chaining Cout back into the next nibble's Cin. Valid/ready handshakes on both sides let it sit between operand producers and result consumers in the datapath.

## Interface
- WIDTH, 16, operand/result width in bits; multiple of 4, minimum 4. NIB = WIDTH/4.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  block can accept an operand pair
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in for the LSB nibble
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- sum  output  WIDTH  A + B + cin, modulo 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  signed overflow; present only with CLA_SERIAL_OVF_EN

## Operation
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- States:
  - IDLE: in_ready=1.
  - RUN: in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=0.
- IDLE → RUN on in_valid && in_ready:
  - a and b load into shift registers.
  - Carry register loads cin.
  - Nibble counter clears to 0.
  - Result register clears.
- RUN, each cycle:
  - The low nibbles of the shift registers plus the carry register drive the 4-bit stage.
  - Stage Sum shifts into the result register from the top.
  - Stage Cout loads the carry register.
  - Operand registers shift right by 4.
  - Counter increments.
- RUN → DONE on the edge that processes nibble NIB-1. cout equals the final carry register.
- DONE → IDLE on out_valid && out_ready.
- While out_valid=1 and out_ready=0, sum, cout and ovf hold stable.
- in_valid is ignored while not in IDLE. Operands must not be re-sampled.
- Arithmetic:
  - sum = (a+b+cin) mod 2^WIDTH.
  - cout = bit WIDTH of the full sum.
  - Counter width is $clog2(NIB)+1.
- rst=1 has priority in every state, including mid-RUN. It aborts the operation with no result produced.
- Reset values: state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, counter=0, carry=0.

## Timing
- Acceptance edge E0.
- Nibbles are computed on edges E1..E_NIB.
- out_valid is high after edge E_NIB: latency NIB cycles from acceptance. For WIDTH=16 this is 4.
- Earliest output handshake is at E_NIB+1, which returns to IDLE. Earliest next acceptance is E_NIB+2, so the minimum issue period is NIB+2 cycles.
- The combinational path per cycle is one 4-bit lookahead stage only. There is no WIDTH-long ripple.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Configuration
- CLA_SERIAL_OVF_EN defined:
  - MSBs of a and b are captured at acceptance.
  - ovf = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb), registered alongside the DONE transition.
  - ovf is held with sum and reset to 0.
- Undefined: ovf port and its capture registers do not exist. All other behaviour is identical.

## Structure
- Shared package cla_pkg holds:
  - NIBBLE_W = 4.
  - State typedef enum {IDLE, RUN, DONE}.
- One sub-module instance: the existing cla_4bit (A, B, Cin, Sum, Cout), driven from the operand shift registers and carry register.
- Elaboration check: WIDTH % 4 == 0 and WIDTH >= 4. Otherwise fatal.

## Test plan
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1; out_valid rises 4 cycles after acceptance.
- WIDTH=16, a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0. in_valid held high through RUN/DONE → exactly one operation accepted.
- Backpressure: out_ready=0 for 3 cycles after out_valid → sum/cout stable, in_ready=0. out_ready=1 → IDLE next cycle, in_ready=1.
- rst pulsed on the 2nd RUN cycle of 0xAAAA+0x5555 → next cycle IDLE, out_valid=0, sum=0, cout=0. The following 0x0001+0x0001 → 0x0002.
- CLA_SERIAL_OVF_EN, WIDTH=16: 0x7FFF+0x0001 → sum=0x8000, ovf=1, cout=0; 0xFFFF+0x0001 → ovf=0, cout=1.
- WIDTH=4: a=0xF, b=0xF, cin=1 → sum=0xF, cout=1, latency 1 cycle. Back-to-back issue period is 3 cycles.
